// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared state encodings, operation selects and digit-count helper for add_sub_serial.
package add_sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction
endpackage

// File: rtl/add_sub_digit.sv
// add_sub_digit: combinational DIGIT-bit ripple slice with carry out and carry into the slice MSB.
module add_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT:0] sum;
  assign sum   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cin};
  assign s_d   = sum[DIGIT-1:0];
  assign cout  = sum[DIGIT];
  // MSB sum bit is a^b^carry_in, so the incoming carry falls out by XOR
  assign c_msb = s_d[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
endmodule

// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial two's-complement add/subtract with valid/ready handshakes.
// Optional saturation on signed overflow when ADD_SUB_SAT_EN is defined.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("add_sub_serial: WIDTH must be a multiple of DIGIT");
  end
  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt, res;
  logic [CW-1:0]    cnt;
  logic             carry, last, d_cout, d_cmsb, ovf_raw, sub;
  logic [DIGIT-1:0] s_d;
  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (a_r[DIGIT-1:0]),
    .b_d  (b_r[DIGIT-1:0]),
    .cin  (carry),
    .s_d  (s_d),
    .cout (d_cout),
    .c_msb(d_cmsb)
  );
  assign sub       = (sel == SEL_SUB);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == CW'(N - 1));
  assign ovf_raw   = d_cout ^ d_cmsb;
  // result fills from the top so after N digits the LSB digit lands at bit 0
  assign acc_nxt   = (acc >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
`ifdef ADD_SUB_SAT_EN
  // on the final digit a_r[DIGIT-1] is the sign of A, which sets the overflow direction
  assign res = ovf_raw ? {a_r[DIGIT-1], {(WIDTH-1){~a_r[DIGIT-1]}}} : acc_nxt;
`else
  assign res = acc_nxt;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (in_ready && in_valid) begin
      a_r   <= a;
      b_r   <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      a_r   <= a_r >> DIGIT;
      b_r   <= b_r >> DIGIT;
      carry <= d_cout;
      cnt   <= cnt + CW'(1);
      acc   <= acc_nxt;
      if (last) begin
        s    <= res;
        cout <= d_cout;
        ovf  <= ovf_raw;
        zero <= (res == '0);
      end
    end
  end
endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial: randomized and directed checks of add_sub_serial against an integer-arithmetic model.
module tb_add_sub_serial;
  localparam int N = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] s;
  logic        cout, ovf, zero;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // returns {s, cout, ovf, zero} from signed/unsigned integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic msel);
    int sa, sb, r;
    logic [15:0] rs;
    logic c, o;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = msel ? sa - sb : sa + sb;
    o  = (r > 32767) || (r < -32768);
    c  = msel ? (int'(ma) >= int'(mb)) : ((int'(ma) + int'(mb)) > 65535);
    rs = r[15:0];
`ifdef ADD_SUB_SAT_EN
    if (o) rs = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {rs, c, o, rs == 16'h0000};
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tsel,
                        output logic [18:0] got, output int lat, output int acc_cyc);
    a = ta; b = tb2; sel = tsel; in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {s, cout, ovf, zero};
  endtask

  task automatic test_reset;
    tests++;
    if ({in_ready, out_valid} !== 2'b10 || {s, cout, ovf, zero} !== 19'h0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b s=%h c=%b o=%b z=%b, want 1 0 0000 0 0 0",
               in_ready, out_valid, s, cout, ovf, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] va[6] = '{16'h0004, 16'h000D, 16'h0004, 16'h0000, 16'h7FFF, 16'h8000};
    logic [15:0] vb[6] = '{16'h0004, 16'h000C, 16'h0004, 16'h0001, 16'h0001, 16'h0001};
    logic        vs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef ADD_SUB_SAT_EN
    logic [18:0] ve[6] = '{{16'h0008, 3'b000}, {16'h0001, 3'b100}, {16'h0000, 3'b101},
                           {16'hFFFF, 3'b000}, {16'h7FFF, 3'b010}, {16'h8000, 3'b110}};
`else
    logic [18:0] ve[6] = '{{16'h0008, 3'b000}, {16'h0001, 3'b100}, {16'h0000, 3'b101},
                           {16'hFFFF, 3'b000}, {16'h8000, 3'b010}, {16'h7FFF, 3'b110}};
`endif
    logic [18:0] got;
    int lat, ac;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], got, lat, ac);
      tests++;
      if (got !== ve[i]) begin
        fails++;
        $display("FAIL directed%0d: got s=%h c/o/z=%b want s=%h c/o/z=%b", i, got[18:3], got[2:0], ve[i][18:3], ve[i][2:0]);
      end
      tests++;
      if (lat !== N) begin
        fails++;
        $display("FAIL latency%0d: got %0d want %0d", i, lat, N);
      end
      @(posedge clk); #1;
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
        fails++;
        $display("FAIL idle_after%0d: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [18:0] got, exp;
    logic [15:0] ra, rb;
    logic rsel;
    int lat, ac;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rsel = 1'($urandom);
      if (i % 8 == 0) rb = rsel ? ra : 16'(-int'(ra));
      exp = model(ra, rb, rsel);
      run_op(ra, rb, rsel, got, lat, ac);
      tests++;
      if (got !== exp || lat !== N) begin
        fails++;
        $display("FAIL random%0d: %h %s %h got s=%h c/o/z=%b lat=%0d want s=%h c/o/z=%b lat=%0d",
                 i, ra, rsel ? "-" : "+", rb, got[18:3], got[2:0], lat, exp[18:3], exp[2:0], N);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [18:0] exp;
    logic bad;
    exp = model(16'h5A5A, 16'h1234, 1'b1);
    out_ready = 1'b0;
    a = 16'h5A5A; b = 16'h1234; sel = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hFFFF; b = 16'h0F0F; sel = 1'b0;
    repeat (N) begin @(posedge clk); #1; end
    tests++;
    if (out_valid !== 1'b1 || {s, cout, ovf, zero} !== exp) begin
      fails++;
      $display("FAIL bp_result: out_valid=%b s=%h c/o/z=%b want 1 s=%h c/o/z=%b", out_valid, s, {cout, ovf, zero}, exp[18:3], exp[2:0]);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sel = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {s, cout, ovf, zero} !== exp) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bp_hold: out_valid=%b in_ready=%b s=%h want 1 0 %h", out_valid, in_ready, s, exp[18:3]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10 || {s, cout, ovf, zero} !== exp) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b s=%h want 1 0 %h", in_ready, out_valid, s, exp[18:3]);
    end
  endtask

  task automatic test_mid_reset;
    logic [18:0] got;
    logic seen;
    int lat, ac;
    run_op(16'h1111, 16'h0001, 1'b0, got, lat, ac);
    @(posedge clk); #1;
    a = 16'h4321; b = 16'h1111; sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10 || s !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b s=%h want 1 0 0000", in_ready, out_valid, s);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL mid_reset_pulse: out_valid seen=1 want 0");
    end
    run_op(16'h1234, 16'h1111, 1'b0, got, lat, ac);
    tests++;
    if (got !== {16'h2345, 3'b000}) begin
      fails++;
      $display("FAIL post_reset_op: got s=%h c/o/z=%b want s=2345 c/o/z=000", got[18:3], got[2:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [18:0] got, exp;
    logic [15:0] ra, rb;
    logic rsel;
    int lat, ac, prev;
    out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rsel = 1'($urandom);
      exp = model(ra, rb, rsel);
      run_op(ra, rb, rsel, got, lat, ac);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b%0d: got s=%h c/o/z=%b want s=%h c/o/z=%b", i, got[18:3], got[2:0], exp[18:3], exp[2:0]);
      end
      if (prev >= 0) begin
        tests++;
        if (ac - prev !== N + 2) begin
          fails++;
          $display("FAIL b2b_period%0d: got %0d cycles want %0d", i, ac - prev, N + 2);
        end
      end
      prev = ac;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_mid_reset;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on input and output. It succeeds the fixed 4-bit combinational adder/subtractor. Operands of WIDTH bits are processed DIGIT bits per clock, trading latency for area. Status flags are carry, signed overflow and zero. It sits between operand-producing datapath stages and any consumer that can stall.

## Interface
- WIDTH, 16, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails. N = WIDTH/DIGIT.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands/sel valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  1  0: add (A+B), 1: subtract (A−B).
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.

## Operation
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch a, b XOR {WIDTH{sel}} and carry = sel, clear the digit counter, then go to RUN.
  - RUN: each cycle, a DIGIT-wide slice adds the low digits plus carry. The sum digit shifts into the result register from the top, the operand registers shift right by DIGIT, the carry updates and the counter increments. After digit N−1, set s/cout/ovf/zero and go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- a, b and sel are sampled only at the accept edge. Input changes during RUN or DONE are ignored.
- Flags:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - zero is computed on the final s, after saturation if enabled.
- s, cout, ovf and zero are registered. They keep their last value after the result is taken and change only when the next result completes. Only out_valid drops.
- Reset values:
  - state = IDLE, in_ready = 1.
  - out_valid = 0, s = 0, cout = 0, ovf = 0, zero = 0.
  - All internal registers = 0.
- Reset asserted mid-operation aborts the operation. The partial result is discarded and no out_valid pulse is produced.
- DIGIT == WIDTH is legal: N = 1, one RUN cycle.

## Timing
- Accept occurs at edge E0, when in_valid & in_ready.
- RUN occupies the edges after E0. out_valid rises at edge E0+N, so latency is N cycles.
- The output handshake at edge Ed (out_valid & out_ready) returns to IDLE. in_ready is high in the following cycle.
- Back-to-back throughput is one operation per N+2 cycles when out_ready is held high.
- out_ready low holds DONE indefinitely, with s and flags stable and in_ready = 0.
- in_ready is decoded combinationally from the state. It has no combinational path from in_valid or out_ready.

## Configuration
- ADD_SUB_SAT_EN defined:
  - On signed overflow, s saturates to 2^(WIDTH−1)−1 for a positive overflow (operand sign 0) or −2^(WIDTH−1) for a negative one.
  - ovf is still reported as 1.
  - cout is the raw carry.
- ADD_SUB_SAT_EN undefined: s wraps modulo 2^WIDTH.
- The port list is identical in both builds.

## Structure
- Package add_sub_pkg holds:
  - state encodings IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - SEL_ADD = 1'b0, SEL_SUB = 1'b1;
  - a function computing N from WIDTH/DIGIT.
- One sub-module, add_sub_digit, parametrised on DIGIT:
  - combinational ripple slice with inputs a_d, b_d, cin;
  - outputs s_d, cout, and c_msb (the carry into the slice MSB, used for ovf on the final digit).
- The top level holds the FSM, digit counter, shift registers, flag logic and optional saturation.

## Test plan
All scenarios use WIDTH = 16, DIGIT = 4 (N = 4).
- a=0x0004, b=0x0004, sel=0 → s=0x0008, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- a=0x000D, b=0x000C, sel=1 → s=0x0001, cout=1, ovf=0; a=0x0004, b=0x0004, sel=1 → s=0x0000, zero=1, cout=1.
- a=0x0000, b=0x0001, sel=1 → s=0xFFFF, cout=0 (borrow), ovf=0, zero=0.
- a=0x7FFF, b=0x0001, sel=0 → ovf=1; s=0x8000 without ADD_SUB_SAT_EN, s=0x7FFF with it. a=0x8000, b=0x0001, sel=1 → ovf=1; s=0x7FFF wrapped, or 0x8000 saturated.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1, s stable, in_ready=0, new in_valid ignored. Release → IDLE next cycle. Operands changed during RUN do not affect s.
- Reset: drop rst_n in RUN cycle 2 → immediately in_ready=1, out_valid=0, s=0. After release, a fresh operation 0x1234+0x1111 → s=0x2345.
